// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among N_REQ requesters.
// In-flight operations carry a requester tag through a latency-matched pipe.
module alu_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]       alu_operand_a,
    output logic [DATA_W-1:0]       alu_operand_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_zero,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [N_REQ*DATA_W-1:0] rsp_result,
    output logic [N_REQ-1:0]        rsp_zero,
    output logic                    busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StInflight, StDone} state_e;

    state_e            state_q [N_REQ];
    state_e            state_d [N_REQ];
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  eligible;
    logic              grant_vld;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   cand;

    // Stage 0 is loaded at issue; stage ALU_LAT lines up with alu_result.
    logic [ALU_LAT:0]  tag_vld_q;
    logic [IdxW-1:0]   tag_id_q [ALU_LAT+1];
    logic              done_vld;
    logic [IdxW-1:0]   done_id;

    logic [DATA_W-1:0] result_q [N_REQ];
    logic [N_REQ-1:0]  zero_q;

    assign done_vld = tag_vld_q[ALU_LAT];
    assign done_id  = tag_id_q[ALU_LAT];

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (state_q[i] == StIdle);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // No handshake is offered while reset is held, so nothing is lost at a reset edge.
    always_comb begin
        req_ready = '0;
        if (grant_vld && reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == IdxW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                StIdle: begin
                    if (grant_vld && grant_idx == IdxW'(i)) state_d[i] = StInflight;
                end
                StInflight: begin
                    if (done_vld && done_id == IdxW'(i)) state_d[i] = StDone;
                end
                StDone: begin
                    if (rsp_ready[i]) state_d[i] = StIdle;
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            tag_vld_q     <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_op        <= '0;
            zero_q        <= '0;
            for (int unsigned s = 0; s <= ALU_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                state_q[i]  <= StIdle;
                result_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q[0] <= grant_vld;
            tag_id_q[0]  <= grant_idx;
            for (int unsigned s = 1; s <= ALU_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            if (grant_vld) begin
                alu_operand_a <= req_a[32'(grant_idx)*DATA_W +: DATA_W];
                alu_operand_b <= req_b[32'(grant_idx)*DATA_W +: DATA_W];
                alu_op        <= req_op[32'(grant_idx)*OP_W +: OP_W];
            end
            if (done_vld) begin
                result_q[done_id] <= alu_result;
                zero_q[done_id]   <= alu_zero;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        rsp_result = '0;
        rsp_valid  = '0;
        busy       = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_result[i*DATA_W +: DATA_W] = result_q[i];
            rsp_valid[i] = (state_q[i] == StDone);
            busy         = busy | (state_q[i] != StIdle);
        end
    end

    assign rsp_zero = zero_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter that shares one ALU_Pipelined instance among N_REQ requesters. Each requester issues at most one operation at a time through a valid/ready request port. The arbiter registers the granted operands into the ALU and tracks each in-flight operation with a requester tag through a latency-matched pipe. When the result arrives, it is held in a per-requester result register until that requester accepts it through a valid/ready response port.

Parameters:
N_REQ, 4, number of requesters (2..8)
ALU_LAT, 1, edges from ALU input change to matching alu_result/alu_zero (>=1)
DATA_W, 32, operand/result width
OP_W, 5, ALU opcode width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  request accepted this cycle (combinational, at most one bit high)
req_a  in  N_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  N_REQ*DATA_W  operand B, same packing
req_op  in  N_REQ*OP_W  opcode, requester i at [i*OP_W +: OP_W]
alu_operand_a  out  DATA_W  registered operand A to ALU
alu_operand_b  out  DATA_W  registered operand B to ALU
alu_op  out  OP_W  registered opcode to ALU
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  N_REQ  result available per requester (registered)
rsp_ready  in  N_REQ  requester consumes result
rsp_result  out  N_REQ*DATA_W  held result per requester
rsp_zero  out  N_REQ  held zero flag per requester
busy  out  1  any requester not IDLE

Behaviour:
- Per-requester state machine: IDLE -> INFLIGHT on request handshake; INFLIGHT -> DONE when its tag exits the pipe; DONE -> IDLE on rsp_valid&rsp_ready.
- Eligible(i) = req_valid[i] & state[i]==IDLE.
- Grant goes to the first eligible requester scanning upward from rr_ptr with wrap. req_ready is one-hot or zero.
- On handshake with requester g: rr_ptr <= (g+1) mod N_REQ. rr_ptr is unchanged when there is no grant.
- One grant per cycle maximum, so back-to-back issue from different requesters is allowed every cycle.
- Issue stage: on handshake edge T, alu_operand_a/b/alu_op <= req_a/b/op[g], and tag pipe stage 0 <= {valid=1, id=g}. With no grant, ALU inputs hold their previous values and stage 0 valid <= 0.
- The tag pipe is ALU_LAT stages deep. Its output valid means alu_result/alu_zero belong to tag id.
- At that edge: result_reg[id] <= alu_result, zero_reg[id] <= alu_zero, state[id] <= DONE.
- Latency: request accepted at edge T, so rsp_valid[g] is high after edge T+1+ALU_LAT.
- rsp_valid[i] = (state[i]==DONE). rsp_result/rsp_zero stay stable while rsp_valid is high and rsp_ready is low.
- Requester i gets req_ready[i]=0 in any state except IDLE, including the cycle of its response handshake. It becomes eligible the cycle after returning to IDLE.
- A completion and a new grant in the same cycle are independent (different requesters by construction).
- Reset (reset==0 at an edge):
  - All states IDLE, rr_ptr=0, tag pipe valids 0.
  - alu_operand_a/b=0, alu_op=0, result/zero regs 0.
  - rsp_valid=0, busy=0.
  - In-flight operations are discarded and produce no response after reset.
- Inputs of a requester not being granted are ignored. req_* of the granted requester are sampled only at the handshake edge.
- Opcode is passed through unchecked; undefined opcodes return whatever the ALU produces.

Test Plan:
- Single op, ALU_LAT=1: requester 0 sends a=10, b=15, op=00000 at edge T -> req_ready[0]=1 at T; rsp_valid[0] high after edge T+2 with rsp_result=25, rsp_zero=0. Hold rsp_ready=1 -> state IDLE, busy=0 next cycle.
- Zero flag: requester 2 sends SUB 5-5 (op=00001) -> rsp_result=0, rsp_zero=1. Requester 1 sends NOR 0,0 (op=01001) -> rsp_result=FFFFFFFF, rsp_zero=0.
- Contention: all 4 assert req_valid at reset release with ADD i+100 -> grants on 4 consecutive edges in order 0,1,2,3, responses 100,101,102,103 in the same order, rr_ptr=0 afterwards.
- Fairness: after a grant to requester 1 (rr_ptr=2), requesters 0 and 3 request together -> 3 granted first, 0 on the next cycle.
- Backpressure: requester 0 result 25 with rsp_ready[0]=0 for 10 cycles -> rsp_valid[0] and rsp_result=25 stable, req_ready[0]=0 despite req_valid[0]=1. Requester 1 is still granted and completes meanwhile. Raising rsp_ready[0] -> IDLE, re-grant on the following cycle.
- Reset mid-flight: assert reset one cycle after a grant -> all rsp_valid=0, busy=0, no response appears afterwards. A post-reset request completes normally.
